// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard detection, stage stall/bubble drive, IDLE/RUN/HALTED
// run-state machine and saturating performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [3:0]       m_stat_i,
    input  logic [3:0]       W_stat_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic [3:0]       cpu_stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o,
    output logic [CNT_W-1:0] ret_cnt_o
);
    localparam logic [3:0] SAOK = 4'h1, SHLT = 4'h2, SADR = 4'h3, SINS = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5, IJXX = 4'h7, IRET = 4'h9, IPOPQ = 4'hB;
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_stat;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       w_inc;

    logic w_lu, w_ret, w_mis, w_flt_m, w_flt_w;

    assign w_lu    = (E_icode_i == IMRMOVQ || E_icode_i == IPOPQ) && (E_dstM_i != RNONE)
                     && (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    assign w_ret   = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    assign w_mis   = (E_icode_i == IJXX) && !e_Cnd_i;
    assign w_flt_m = (m_stat_i == SHLT) || (m_stat_i == SADR) || (m_stat_i == SINS);
    assign w_flt_w = (W_stat_i == SHLT) || (W_stat_i == SADR) || (W_stat_i == SINS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_stat  <= SAOK;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_RUN && w_flt_w)
                r_stat <= W_stat_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        F_stall_o    = 1'b1;
        D_stall_o    = 1'b1;
        D_bubble_o   = 1'b0;
        E_bubble_o   = 1'b1;
        M_bubble_o   = 1'b1;
        W_stall_o    = 1'b1;
        cpu_stat_o   = SAOK;
        halted_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i)
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                F_stall_o  = w_lu || w_ret;
                D_stall_o  = w_lu;
                D_bubble_o = w_mis || (w_ret && !w_lu);
                E_bubble_o = w_mis || w_lu;
                M_bubble_o = w_flt_m || w_flt_w;
                W_stall_o  = w_flt_w;
                if (w_flt_w)
                    w_state_next = ST_HALTED;
            end
            ST_HALTED: begin
                cpu_stat_o = r_stat;
                halted_o   = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Counter order: cycles, load/use, mispredict, ret bubbles (ret masked by load/use).
    assign w_inc = {w_ret && !w_lu, w_mis, w_lu, 1'b1};

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        always_ff @(posedge clk_i) begin
            if (rst_i)
                r_cnt[gi] <= '0;
            else if (r_state == ST_RUN && w_inc[gi] && r_cnt[gi] != CNT_MAX)
                r_cnt[gi] <= r_cnt[gi] + CNT_ONE;
        end
    end

    assign cyc_cnt_o = r_cnt[0];
    assign lu_cnt_o  = r_cnt[1];
    assign mis_cnt_o = r_cnt[2];
    assign ret_cnt_o = r_cnt[3];
endmodule
